trigger_frame_arbiter: RTL and testbench

- Merges frame streams from N_CH trigger channel instances onto one DOUT_WIDTH readout stream in the RD_CLK domain.
- Sits between the per-channel trigger output ports (DOUT/oVALID/iREADY) and the downstream readout module.
- Arbitrates round-robin at frame granularity; a frame is never interleaved with another channel's frame.
- A watchdog aborts and drains any channel that stalls mid-frame.

---
 rtl/trigger_frame_arbiter_if.sv | 29 ++
 rtl/trigger_frame_arbiter.sv | 157 +++++++++++++++
 tb/tb_trigger_frame_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_frame_arbiter_if.sv
// Channel-side and readout-side handshake bundle for the trigger frame arbiter.
interface trigger_frame_arbiter_if #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CH_ID_WIDTH = 2,
  parameter int unsigned DOUT_WIDTH  = 64
);
  logic [N_CH*DOUT_WIDTH-1:0] CH_DOUT;
  logic [N_CH-1:0]            CH_VALID;
  logic [N_CH-1:0]            CH_LAST;
  logic [N_CH-1:0]            CH_READY;
  logic [N_CH-1:0]            CH_ENABLE;
  logic [DOUT_WIDTH-1:0]      DOUT;
  logic                       oVALID;
  logic                       oLAST;
  logic [CH_ID_WIDTH-1:0]     oCH_ID;
  logic                       iREADY;

  // Arbiter side: consumes channel streams, produces the merged stream.
  modport master (
    input  CH_DOUT, CH_VALID, CH_LAST, CH_ENABLE, iREADY,
    output CH_READY, DOUT, oVALID, oLAST, oCH_ID
  );

  // Environment side: trigger channels plus the downstream readout.
  modport slave (
    output CH_DOUT, CH_VALID, CH_LAST, CH_ENABLE, iREADY,
    input  CH_READY, DOUT, oVALID, oLAST, oCH_ID
  );
endinterface

// File: rtl/trigger_frame_arbiter.sv
// Frame-granular round-robin merge of N_CH trigger channels onto one readout
// stream, with a mid-frame stall watchdog that aborts and drains the channel.
module trigger_frame_arbiter #(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned CH_ID_WIDTH       = 2,
  parameter int unsigned DOUT_WIDTH        = 64,
  parameter int unsigned TIMEOUT_CYCLES    = 256,
  parameter int unsigned TIMEOUT_CNT_WIDTH = 9
) (
  input  logic                          RD_CLK,
  input  logic                          RD_RESET,
  trigger_frame_arbiter_if.master       bus,
  output logic [15:0]                   ABORT_CNT,
  output logic                          BUSY
);

  localparam int unsigned PAD_WIDTH = DOUT_WIDTH - 16;

  typedef enum logic [1:0] {IDLE, STREAM, ABORT, DRAIN} state_t;

  state_t                       state;
  logic [CH_ID_WIDTH-1:0]       grant;
  logic [CH_ID_WIDTH-1:0]       last_grant;
  logic [TIMEOUT_CNT_WIDTH-1:0] tcnt;
  logic [DOUT_WIDTH-1:0]        dout_q;
  logic                         ovalid_q;
  logic                         olast_q;
  logic [CH_ID_WIDTH-1:0]       och_q;
  logic [15:0]                  abort_cnt_q;
  logic                         busy_q;

  logic                         out_free;
  logic [N_CH-1:0]              cand;
  logic                         pick_valid;
  logic [CH_ID_WIDTH-1:0]       pick;
  logic [CH_ID_WIDTH-1:0]       idx;
  logic [N_CH-1:0]              ready_c;
  logic [DOUT_WIDTH-1:0]        ch_word [N_CH];
  logic                         accept;
  logic [DOUT_WIDTH-1:0]        abort_word;

  assign out_free   = !ovalid_q || bus.iREADY;
  assign cand       = bus.CH_VALID & bus.CH_ENABLE;
  assign accept     = (state == STREAM) && bus.CH_VALID[grant] && out_free;
  assign abort_word = {8'hEE, 8'(grant), PAD_WIDTH'(0)};

  // Split the flat channel data bus into per-channel words.
  always_comb begin
    for (int k = 0; k < int'(N_CH); k++) begin
      ch_word[k] = bus.CH_DOUT[k*DOUT_WIDTH +: DOUT_WIDTH];
    end
  end

  // Round-robin search starting after last_grant; nearest candidate wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int i = int'(N_CH); i >= 1; i--) begin
      idx = CH_ID_WIDTH'((int'(last_grant) + i) % int'(N_CH));
      if (cand[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  // Channel ready: follows output space while streaming, forced high while draining.
  always_comb begin
    ready_c = '0;
    if (state == STREAM) begin
      ready_c[grant] = out_free;
    end else if (state == DRAIN) begin
      ready_c[grant] = 1'b1;
    end
  end

  assign bus.CH_READY = ready_c;
  assign bus.DOUT     = dout_q;
  assign bus.oVALID   = ovalid_q;
  assign bus.oLAST    = olast_q;
  assign bus.oCH_ID   = och_q;
  assign ABORT_CNT    = abort_cnt_q;
  assign BUSY         = busy_q;

  // Arbitration FSM, watchdog and registered output stage.
  always_ff @(posedge RD_CLK or posedge RD_RESET) begin
    if (RD_RESET) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= CH_ID_WIDTH'(N_CH - 1);
      tcnt        <= '0;
      dout_q      <= '0;
      ovalid_q    <= 1'b0;
      olast_q     <= 1'b0;
      och_q       <= '0;
      abort_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_free) ovalid_q <= 1'b0;
          if (pick_valid) begin
            grant      <= pick;
            last_grant <= pick;
            tcnt       <= '0;
            state      <= STREAM;
            busy_q     <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            dout_q   <= ch_word[grant];
            olast_q  <= bus.CH_LAST[grant];
            och_q    <= grant;
            ovalid_q <= 1'b1;
            tcnt     <= '0;
            if (bus.CH_LAST[grant]) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            if (out_free) ovalid_q <= 1'b0;
            if (tcnt == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES)) begin
              state <= ABORT;
            end else if (out_free) begin
              // No accept with space available means the granted channel is idle.
              tcnt <= tcnt + TIMEOUT_CNT_WIDTH'(1);
            end
          end
        end
        ABORT: begin
          if (out_free) begin
            dout_q   <= abort_word;
            olast_q  <= 1'b1;
            och_q    <= grant;
            ovalid_q <= 1'b1;
            if (abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_free) ovalid_q <= 1'b0;
          if (bus.CH_VALID[grant] && bus.CH_LAST[grant]) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trigger_frame_arbiter.sv
// Directed bench for trigger_frame_arbiter: per-channel word queues feed the
// channel ports, a downstream log records every output transfer.
module tb_trigger_frame_arbiter;

  localparam int unsigned N_CH              = 4;
  localparam int unsigned CH_ID_WIDTH       = 2;
  localparam int unsigned DOUT_WIDTH        = 64;
  localparam int unsigned TIMEOUT_CYCLES    = 8;
  localparam int unsigned TIMEOUT_CNT_WIDTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] abort_cnt;
  logic        busy;

  always #5 clk = ~clk;

  trigger_frame_arbiter_if #(
    .N_CH(N_CH), .CH_ID_WIDTH(CH_ID_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)
  ) bus ();

  trigger_frame_arbiter #(
    .N_CH(N_CH), .CH_ID_WIDTH(CH_ID_WIDTH), .DOUT_WIDTH(DOUT_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_CNT_WIDTH(TIMEOUT_CNT_WIDTH)
  ) dut (
    .RD_CLK(clk),
    .RD_RESET(rst),
    .bus(bus),
    .ABORT_CNT(abort_cnt),
    .BUSY(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Channel source queues: {last, data}
  logic [64:0]     src [N_CH][16];
  int              head [N_CH];
  int              tail [N_CH];
  logic [N_CH-1:0] hold;

  // Downstream transfer log
  logic [63:0] log_d   [64];
  logic        log_l   [64];
  logic [1:0]  log_id  [64];
  int          log_cyc [64];
  int          log_n;

  logic [63:0] e2_d  [10] = '{64'hA0, 64'hA1, 64'hB0, 64'hB1, 64'hC0,
                              64'hC1, 64'hD0, 64'hD1, 64'hA2, 64'hA3};
  logic        e2_l  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0]  e2_id [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [63:0] e5_d  [8]  = '{64'h50, 64'h51, 64'h70, 64'h71, 64'h52, 64'h53, 64'h72, 64'h73};
  logic [1:0]  e5_id [8]  = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd3, 2'd3};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [63:0] d, input logic l);
    src[ch][tail[ch]] = {l, d};
    tail[ch]++;
  endtask

  task automatic flush();
    for (int k = 0; k < int'(N_CH); k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < int'(N_CH); k++) begin
      if (head[k] != tail[k] && !hold[k]) begin
        bus.CH_VALID[k]          = 1'b1;
        bus.CH_LAST[k]           = src[k][head[k]][64];
        bus.CH_DOUT[k*64 +: 64]  = src[k][head[k]][63:0];
      end else begin
        bus.CH_VALID[k]          = 1'b0;
        bus.CH_LAST[k]           = 1'b0;
        bus.CH_DOUT[k*64 +: 64]  = 64'h0;
      end
    end
  endtask

  // One clock: sample handshakes mid-cycle, then advance queues after the edge.
  task automatic tick();
    logic [N_CH-1:0] fire;
    logic            ofire;
    logic [63:0]     od;
    logic            ol;
    logic [1:0]      oid;
    @(negedge clk);
    fire  = bus.CH_READY & bus.CH_VALID;
    ofire = bus.oVALID & bus.iREADY;
    od    = bus.DOUT;
    ol    = bus.oLAST;
    oid   = bus.oCH_ID;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (fire[k]) head[k]++;
    end
    if (ofire && log_n < 64) begin
      log_d[log_n]   = od;
      log_l[log_n]   = ol;
      log_id[log_n]  = oid;
      log_cyc[log_n] = cyc;
      log_n++;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    rst           = 1'b1;
    bus.iREADY    = 1'b1;
    bus.CH_ENABLE = '1;
    bus.CH_VALID  = '0;
    bus.CH_LAST   = '0;
    bus.CH_DOUT   = '0;
    hold          = '0;
    log_n         = 0;
    flush();
    drive();
    #22;
    check("rst_dout",   bus.DOUT, 64'h0);
    check("rst_ovalid", 64'(bus.oVALID), 64'd0);
    check("rst_olast",  64'(bus.oLAST), 64'd0);
    check("rst_chid",   64'(bus.oCH_ID), 64'd0);
    check("rst_ready",  64'(bus.CH_READY), 64'd0);
    check("rst_abort",  64'(abort_cnt), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single channel, 3-word frame
    push(0, 64'h1, 1'b0);
    push(0, 64'h2, 1'b0);
    push(0, 64'h3, 1'b1);
    drive();
    tick();
    check("t1_busy_arb",   64'(busy), 64'd1);
    check("t1_ovalid_arb", 64'(bus.oVALID), 64'd0);
    check("t1_ready",      64'(bus.CH_READY), 64'h1);
    tick();
    check("t1_d1",     bus.DOUT, 64'h1);
    check("t1_v1",     64'(bus.oVALID), 64'd1);
    check("t1_id1",    64'(bus.oCH_ID), 64'd0);
    check("t1_last1",  64'(bus.oLAST), 64'd0);
    tick();
    check("t1_d2",     bus.DOUT, 64'h2);
    tick();
    check("t1_d3",     bus.DOUT, 64'h3);
    check("t1_last3",  64'(bus.oLAST), 64'd1);
    check("t1_busy",   64'(busy), 64'd0);
    tick();
    check("t1_vclr",   64'(bus.oVALID), 64'd0);

    // Round-robin across four always-valid channels
    do_reset();
    flush();
    log_n = 0;
    push(0, 64'hA0, 1'b0); push(0, 64'hA1, 1'b1);
    push(0, 64'hA2, 1'b0); push(0, 64'hA3, 1'b1);
    push(1, 64'hB0, 1'b0); push(1, 64'hB1, 1'b1);
    push(2, 64'hC0, 1'b0); push(2, 64'hC1, 1'b1);
    push(3, 64'hD0, 1'b0); push(3, 64'hD1, 1'b1);
    drive();
    repeat (20) tick();
    check("t2_count", 64'(log_n), 64'd10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2_d%0d", i),  log_d[i], e2_d[i]);
      check($sformatf("t2_l%0d", i),  64'(log_l[i]), 64'(e2_l[i]));
      check($sformatf("t2_id%0d", i), 64'(log_id[i]), 64'(e2_id[i]));
    end
    check("t2_inframe_gap", 64'(log_cyc[1] - log_cyc[0]), 64'd1);
    check("t2_frame_gap",   64'(log_cyc[2] - log_cyc[1]), 64'd2);
    check("t2_span",        64'(log_cyc[9] - log_cyc[0]), 64'd13);

    // Backpressure with granted channel idle: no loss, no duplicate, no abort
    flush();
    log_n = 0;
    push(1, 64'h11, 1'b0);
    push(1, 64'h12, 1'b0);
    push(1, 64'h13, 1'b1);
    drive();
    tick();
    tick();
    check("t3_d_first", bus.DOUT, 64'h11);
    check("t3_id",      64'(bus.oCH_ID), 64'd1);
    bus.iREADY = 1'b0;
    hold[1]    = 1'b1;
    drive();
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("t3_hold_d%0d", i),     bus.DOUT, 64'h11);
      check($sformatf("t3_hold_v%0d", i),     64'(bus.oVALID), 64'd1);
      check($sformatf("t3_hold_ready%0d", i), 64'(bus.CH_READY), 64'd0);
    end
    bus.iREADY = 1'b1;
    hold[1]    = 1'b0;
    drive();
    repeat (4) tick();
    check("t3_count", 64'(log_n), 64'd3);
    check("t3_w0",    log_d[0], 64'h11);
    check("t3_w1",    log_d[1], 64'h12);
    check("t3_w2",    log_d[2], 64'h13);
    check("t3_l2",    64'(log_l[2]), 64'd1);
    check("t3_l1",    64'(log_l[1]), 64'd0);
    check("t3_abort", 64'(abort_cnt), 64'd0);
    check("t3_busy",  64'(busy), 64'd0);

    // Watchdog abort on ch2, then drain its stale frame
    flush();
    push(2, 64'h21, 1'b0);
    drive();
    repeat (11) tick();
    check("t4_pre_valid", 64'(bus.oVALID), 64'd0);
    check("t4_pre_busy",  64'(busy), 64'd1);
    check("t4_pre_abort", 64'(abort_cnt), 64'd0);
    tick();
    check("t4_abort_d",   bus.DOUT, 64'hEE02000000000000);
    check("t4_abort_l",   64'(bus.oLAST), 64'd1);
    check("t4_abort_id",  64'(bus.oCH_ID), 64'd2);
    check("t4_abort_v",   64'(bus.oVALID), 64'd1);
    check("t4_abort_cnt", 64'(abort_cnt), 64'd1);
    log_n      = 0;
    bus.iREADY = 1'b0;
    push(2, 64'h22, 1'b0);
    push(2, 64'h23, 1'b0);
    push(2, 64'h24, 1'b1);
    push(3, 64'h31, 1'b1);
    push(0, 64'h01, 1'b1);
    drive();
    #1;
    check("t4_drain_ready", 64'(bus.CH_READY), 64'h4);
    repeat (3) tick();
    check("t4_drained",   64'(tail[2] - head[2]), 64'd0);
    check("t4_ch3_kept",  64'(tail[3] - head[3]), 64'd1);
    check("t4_busy_done", 64'(busy), 64'd0);
    check("t4_held_d",    bus.DOUT, 64'hEE02000000000000);
    bus.iREADY = 1'b1;
    drive();
    repeat (5) tick();
    check("t4_count",  64'(log_n), 64'd3);
    check("t4_log0",   log_d[0], 64'hEE02000000000000);
    check("t4_log1",   log_d[1], 64'h31);
    check("t4_log1id", 64'(log_id[1]), 64'd3);
    check("t4_log2",   log_d[2], 64'h01);
    check("t4_log2id", 64'(log_id[2]), 64'd0);

    // Enable mask: only ch1 and ch3 served; disabling ch1 mid-frame keeps the frame
    flush();
    log_n         = 0;
    bus.CH_ENABLE = 4'b1010;
    push(0, 64'h40, 1'b0); push(0, 64'h41, 1'b1);
    push(1, 64'h50, 1'b0); push(1, 64'h51, 1'b1);
    push(1, 64'h52, 1'b0); push(1, 64'h53, 1'b1);
    push(2, 64'h60, 1'b0); push(2, 64'h61, 1'b1);
    push(3, 64'h70, 1'b0); push(3, 64'h71, 1'b1);
    push(3, 64'h72, 1'b0); push(3, 64'h73, 1'b1);
    drive();
    repeat (8) tick();
    check("t5_mid_d",  bus.DOUT, 64'h52);
    check("t5_mid_id", 64'(bus.oCH_ID), 64'd1);
    bus.CH_ENABLE = 4'b1000;
    repeat (8) tick();
    check("t5_count", 64'(log_n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_d%0d", i),  log_d[i], e5_d[i]);
      check($sformatf("t5_id%0d", i), 64'(log_id[i]), 64'(e5_id[i]));
    end
    check("t5_ch0_untouched", 64'(tail[0] - head[0]), 64'd2);
    check("t5_ch2_untouched", 64'(tail[2] - head[2]), 64'd2);
    check("t5_busy",          64'(busy), 64'd0);

    // Asynchronous reset mid-frame, then ch0 regains first priority
    bus.CH_ENABLE = '1;
    flush();
    log_n = 0;
    push(1, 64'h81, 1'b0);
    push(1, 64'h82, 1'b0);
    push(1, 64'h83, 1'b1);
    drive();
    repeat (3) tick();
    check("t6_pre_d", bus.DOUT, 64'h82);
    rst = 1'b1;
    #1;
    check("t6_rst_d",     bus.DOUT, 64'h0);
    check("t6_rst_v",     64'(bus.oVALID), 64'd0);
    check("t6_rst_l",     64'(bus.oLAST), 64'd0);
    check("t6_rst_id",    64'(bus.oCH_ID), 64'd0);
    check("t6_rst_ready", 64'(bus.CH_READY), 64'd0);
    check("t6_rst_busy",  64'(busy), 64'd0);
    flush();
    push(1, 64'hA1, 1'b1);
    push(0, 64'h91, 1'b1);
    #1;
    rst = 1'b0;
    drive();
    repeat (2) tick();
    check("t6_first_d",  bus.DOUT, 64'h91);
    check("t6_first_id", 64'(bus.oCH_ID), 64'd0);
    repeat (3) tick();
    check("t6_second_d",  bus.DOUT, 64'hA1);
    check("t6_second_id", 64'(bus.oCH_ID), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
